// File: rtl/vend_pkg.sv
// Shared types and constants for the coin vending controller:
// FSM state encoding, coin encodings, default pricing and the
// coin-to-credit conversion helper.
package vend_pkg;

    // Width of every credit/change quantity (credit ceiling is at most 15).
    localparam int unsigned CREDIT_W = 32'd4;

    // Default configuration of the controller.
    localparam int unsigned DEFAULT_PRICE      = 32'd5;
    localparam int unsigned DEFAULT_MAX_CREDIT = 32'd8;
    localparam int unsigned DEFAULT_ITEM_HOLD  = 32'd4;

    // Coin acceptor encodings.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_FOUR = 2'b11;

    // Controller states. REFUND is only reachable when cancel support is built.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_REFUND = 3'd4
    } vend_state_e;

    // Credit value of one coin in farthing units; the invalid code is worth 0.
    function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] coin);
        logic [CREDIT_W-1:0] units;
        case (coin)
            COIN_ONE:  units = 4'd1;
            COIN_TWO:  units = 4'd2;
            COIN_FOUR: units = 4'd4;
            default:   units = 4'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/change_unit.sv
// Change/refund down-counter with a valid/ready handshake towards the
// change dispenser. Loaded with a unit count, it offers one farthing per
// cycle until every unit has been taken. The offer never drops until the
// current unit is accepted.
module change_unit
    import vend_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] count_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [CREDIT_W-1:0] remaining_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] remaining_r;
    logic [CREDIT_W-1:0] remaining_d;
    logic                valid_r;
    logic                valid_d;
    logic                handshake_s;

    // A unit leaves only when it is offered and the dispenser takes it.
    assign handshake_s = valid_r & ready_i;

    // done flags the edge on which the final unit is handed over, so the
    // parent can leave its change state on that same edge.
    assign done_o      = handshake_s & (remaining_r == 4'd1);
    assign valid_o     = valid_r;
    assign remaining_o = remaining_r;

    // Next count and offer flag: load wins, otherwise count down per handshake.
    always_comb begin
        remaining_d = remaining_r;
        valid_d     = valid_r;
        if (load_i) begin
            remaining_d = count_i;
            valid_d     = (count_i != 4'd0);
        end else if (handshake_s) begin
            remaining_d = remaining_r - 4'd1;
            valid_d     = (remaining_r != 4'd1);
        end else begin
            remaining_d = remaining_r;
            valid_d     = valid_r;
        end
    end

    // Counter and offer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            remaining_r <= 4'd0;
            valid_r     <= 1'b0;
        end else begin
            remaining_r <= remaining_d;
            valid_r     <= valid_d;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coin vending sequencing controller. Accumulates coin credit, runs the
// item-release phase once the price is reached, then returns any excess
// one farthing at a time through change_unit.
// Optional feature: define VEND_CANCEL_EN to enable cancel/refund; without
// it the cancel input is ignored and credit persists until a vend completes.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = DEFAULT_PRICE,
    parameter int unsigned MAX_CREDIT = DEFAULT_MAX_CREDIT,
    parameter int unsigned ITEM_HOLD  = DEFAULT_ITEM_HOLD
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                coin_valid_i,
    input  logic [1:0]          coin_value_i,
    input  logic                cancel_i,
    input  logic                change_ready_i,
    output logic                coin_accept_o,
    output logic                coin_reject_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                item_out_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_bits_o,
    output logic                busy_o
);

    // Hold counter counts ITEM_HOLD-1 down to 0; keep at least one bit.
    localparam int unsigned HOLD_W = (ITEM_HOLD > 32'd1) ? $clog2(ITEM_HOLD) : 32'd1;

    vend_state_e         state_r;
    vend_state_e         state_d;
    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W-1:0] change_bits_r;
    logic [CREDIT_W-1:0] change_bits_d;
    logic [HOLD_W-1:0]   hold_r;
    logic [HOLD_W-1:0]   hold_d;
    logic                item_r;
    logic                item_d;
    logic                accept_r;
    logic                accept_d;
    logic                reject_r;
    logic                reject_d;
    logic                busy_r;
    logic                busy_d;

    logic                load_s;
    logic [CREDIT_W-1:0] load_count_s;
    logic                change_valid_s;
    logic [CREDIT_W-1:0] remaining_s;
    logic                done_s;
    logic                handshake_s;
    logic [CREDIT_W-1:0] coin_units_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                cancel_hit_s;

`ifdef VEND_CANCEL_EN
    // Cancel only matters while credit is being accumulated.
    assign cancel_hit_s = cancel_i & (state_r == ST_ACCUM);
`else
    // Cancel is deliberately ignored in this build.
    logic unused_cancel_s;
    assign unused_cancel_s = cancel_i;
    assign cancel_hit_s    = 1'b0;
`endif

    assign coin_units_s = coin_units(coin_value_i);
    assign coin_sum_s   = {1'b0, credit_r} + {1'b0, coin_units_s};
    assign handshake_s  = change_valid_s & change_ready_i;

    change_unit u_change (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_s),
        .count_i     (load_count_s),
        .ready_i     (change_ready_i),
        .valid_o     (change_valid_s),
        .remaining_o (remaining_s),
        .done_o      (done_s)
    );

    // Next-state and next-output decode for the vend sequence.
    always_comb begin
        state_d       = state_r;
        credit_d      = credit_r;
        change_bits_d = change_bits_r;
        hold_d        = hold_r;
        item_d        = 1'b0;
        accept_d      = 1'b0;
        reject_d      = 1'b0;
        load_s        = 1'b0;
        load_count_s  = 4'd0;
        case (state_r)
            ST_IDLE, ST_ACCUM: begin
                if (cancel_hit_s) begin
                    // Cancel beats a simultaneous coin; refund everything held.
                    state_d       = ST_REFUND;
                    change_bits_d = credit_r;
                    load_s        = 1'b1;
                    load_count_s  = credit_r;
                    reject_d      = coin_valid_i;
                end else if (coin_valid_i) begin
                    if ((coin_units_s == 4'd0) || (coin_sum_s > 5'(MAX_CREDIT))) begin
                        reject_d = 1'b1;
                    end else begin
                        accept_d = 1'b1;
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                        if (coin_sum_s >= 5'(PRICE)) begin
                            state_d       = ST_VEND;
                            change_bits_d = coin_sum_s[CREDIT_W-1:0] - 4'(PRICE);
                            item_d        = 1'b1;
                            hold_d        = HOLD_W'(ITEM_HOLD - 32'd1);
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end else begin
                    state_d = state_r;
                end
            end
            ST_VEND: begin
                reject_d = coin_valid_i;
                if (hold_r == '0) begin
                    // Item window over: return excess or finish the transaction.
                    if (change_bits_r != 4'd0) begin
                        state_d      = ST_CHANGE;
                        credit_d     = change_bits_r;
                        load_s       = 1'b1;
                        load_count_s = change_bits_r;
                    end else begin
                        state_d  = ST_IDLE;
                        credit_d = 4'd0;
                    end
                end else begin
                    item_d = 1'b1;
                    hold_d = hold_r - HOLD_W'(1);
                end
            end
            ST_CHANGE: begin
                reject_d = coin_valid_i;
                if (done_s) begin
                    state_d       = ST_IDLE;
                    credit_d      = 4'd0;
                    change_bits_d = 4'd0;
                end else if (handshake_s) begin
                    credit_d = remaining_s - 4'd1;
                end else begin
                    credit_d = credit_r;
                end
            end
`ifdef VEND_CANCEL_EN
            ST_REFUND: begin
                reject_d = coin_valid_i;
                if (done_s) begin
                    state_d       = ST_IDLE;
                    credit_d      = 4'd0;
                    change_bits_d = 4'd0;
                end else if (handshake_s) begin
                    credit_d = remaining_s - 4'd1;
                end else begin
                    credit_d = credit_r;
                end
            end
`endif
            default: begin
                // Unreachable encoding: drop everything and restart clean.
                state_d       = ST_IDLE;
                credit_d      = 4'd0;
                change_bits_d = 4'd0;
                hold_d        = '0;
            end
        endcase
        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE) || (state_d == ST_REFUND);
    end

    // State and registered outputs, all cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= ST_IDLE;
            credit_r      <= 4'd0;
            change_bits_r <= 4'd0;
            hold_r        <= '0;
            item_r        <= 1'b0;
            accept_r      <= 1'b0;
            reject_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_d;
            credit_r      <= credit_d;
            change_bits_r <= change_bits_d;
            hold_r        <= hold_d;
            item_r        <= item_d;
            accept_r      <= accept_d;
            reject_r      <= reject_d;
            busy_r        <= busy_d;
        end
    end

    assign coin_accept_o  = accept_r;
    assign coin_reject_o  = reject_r;
    assign credit_o       = credit_r;
    assign item_out_o     = item_r;
    assign change_valid_o = change_valid_s;
    assign change_bits_o  = change_bits_r;
    assign busy_o         = busy_r;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: a transaction-level model of
// credit, item window and owed change is stepped every clock and compared
// against the DUT every cycle, plus directed scenarios with literal
// expectations and a second instance with a low credit ceiling.
module tb_vend_controller;

    localparam int PRICE      = 5;
    localparam int MAX_CREDIT = 8;
    localparam int ITEM_HOLD  = 4;
`ifdef VEND_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i        = 1'b1;
    logic       coin_valid_i   = 1'b0;
    logic [1:0] coin_value_i   = 2'b00;
    logic       cancel_i       = 1'b0;
    logic       change_ready_i = 1'b0;
    logic       coin_accept_o, coin_reject_o, item_out_o, change_valid_o, busy_o;
    logic [3:0] credit_o, change_bits_o;

    vend_controller #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .ITEM_HOLD(ITEM_HOLD)) dut (
        .clk_i(clk), .reset_i(reset_i), .coin_valid_i(coin_valid_i), .coin_value_i(coin_value_i),
        .cancel_i(cancel_i), .change_ready_i(change_ready_i), .coin_accept_o(coin_accept_o),
        .coin_reject_o(coin_reject_o), .credit_o(credit_o), .item_out_o(item_out_o),
        .change_valid_o(change_valid_o), .change_bits_o(change_bits_o), .busy_o(busy_o)
    );

    // Second instance with a credit ceiling low enough to overflow.
    logic       b_reset      = 1'b1;
    logic       b_coin_valid = 1'b0;
    logic [1:0] b_coin_value = 2'b00;
    logic       b_accept, b_reject, b_item, b_change_valid, b_busy;
    logic [3:0] b_credit, b_change_bits;

    vend_controller #(.PRICE(5), .MAX_CREDIT(6), .ITEM_HOLD(2)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .coin_valid_i(b_coin_valid), .coin_value_i(b_coin_value),
        .cancel_i(1'b0), .change_ready_i(1'b1), .coin_accept_o(b_accept),
        .coin_reject_o(b_reject), .credit_o(b_credit), .item_out_o(b_item),
        .change_valid_o(b_change_valid), .change_bits_o(b_change_bits), .busy_o(b_busy)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_credit, m_item_left, m_owed, m_bits;
    bit m_acc, m_rej;

    task automatic model_step();
        int v;
        if (reset_i) begin
            m_credit = 0; m_item_left = 0; m_owed = 0; m_bits = 0; m_acc = 0; m_rej = 0;
        end else begin
            m_acc = 0; m_rej = 0;
            if (m_item_left > 0 || m_owed > 0) begin
                if (coin_valid_i) m_rej = 1;
                if (m_item_left > 0) begin
                    m_item_left--;
                    if (m_item_left == 0) begin
                        m_owed   = m_bits;
                        m_credit = m_bits;
                    end
                end else if (change_ready_i) begin
                    m_owed--;
                    m_credit = m_owed;
                    if (m_owed == 0) m_bits = 0;
                end
            end else if (CANCEL_EN && cancel_i && m_credit > 0) begin
                m_rej  = coin_valid_i;
                m_owed = m_credit;
                m_bits = m_credit;
            end else if (coin_valid_i) begin
                v = (coin_value_i == 2'b11) ? 4 : int'(coin_value_i);
                if (v == 0 || m_credit + v > MAX_CREDIT) begin
                    m_rej = 1;
                end else begin
                    m_acc = 1;
                    m_credit += v;
                    if (m_credit >= PRICE) begin
                        m_bits      = m_credit - PRICE;
                        m_item_left = ITEM_HOLD;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Compare DUT against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("m_credit",  credit_o,       m_credit);
            cmp("m_accept",  coin_accept_o,  m_acc);
            cmp("m_reject",  coin_reject_o,  m_rej);
            cmp("m_item",    item_out_o,     m_item_left > 0);
            cmp("m_valid",   change_valid_o, (m_item_left == 0) && (m_owed > 0));
            cmp("m_bits",    change_bits_o,  m_bits);
            cmp("m_busy",    busy_o,         (m_item_left > 0) || (m_owed > 0));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_valid_i = 1'b1;
        coin_value_i = v;
        tick();
        coin_valid_i = 1'b0;
        coin_value_i = 2'b00;
    endtask

    task automatic drain(output int n_item, output int n_hs);
        n_item = 0;
        n_hs   = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_o) break;
            if (item_out_o) n_item++;
            if (change_valid_o && change_ready_i) n_hs++;
            tick();
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (change_valid_o) break;
            tick();
        end
        cmp("wait_change_valid", change_valid_o, 1);
    endtask

    initial begin
        int n_item, n_hs;

        // Reset state
        tick(); tick();
        cmp_en = 1'b1;
        cmp("rst_credit", credit_o, 0);
        cmp("rst_busy", busy_o, 0);
        cmp("rst_item", item_out_o, 0);
        cmp("rst_valid", change_valid_o, 0);
        cmp("rst_bits", change_bits_o, 0);
        reset_i = 1'b0;
        b_reset = 1'b0;

        // Overflow on the low-ceiling instance: 4 + 4 > 6 refused, then 4 + 2 vends.
        b_coin_valid = 1'b1; b_coin_value = 2'b11; tick();
        cmp("b_credit4", b_credit, 4);
        cmp("b_accept", b_accept, 1);
        b_coin_value = 2'b11; tick();
        cmp("b_overflow_reject", b_reject, 1);
        cmp("b_overflow_credit", b_credit, 4);
        b_coin_value = 2'b10; tick();
        b_coin_valid = 1'b0; b_coin_value = 2'b00;
        cmp("b_credit6", b_credit, 6);
        cmp("b_item", b_item, 1);
        cmp("b_bits", b_change_bits, 1);

        // Exact price: 4 then 1, no change
        put_coin(2'b11);
        cmp("t1_credit4", credit_o, 4);
        cmp("t1_accept", coin_accept_o, 1);
        put_coin(2'b01);
        cmp("t1_credit5", credit_o, 5);
        cmp("t1_item_first", item_out_o, 1);
        drain(n_item, n_hs);
        cmp("t1_item_cycles", n_item, 4);
        cmp("t1_handshakes", n_hs, 0);
        cmp("t1_credit_end", credit_o, 0);
        cmp("t1_idle", busy_o, 0);

        // 4 then 2: one unit of change
        change_ready_i = 1'b1;
        put_coin(2'b11);
        put_coin(2'b10);
        cmp("t2_credit6", credit_o, 6);
        cmp("t2_bits", change_bits_o, 1);
        drain(n_item, n_hs);
        cmp("t2_item_cycles", n_item, 4);
        cmp("t2_handshakes", n_hs, 1);
        cmp("t2_credit_end", credit_o, 0);

        // 4 then 4: three units with a stuttering dispenser
        change_ready_i = 1'b0;
        put_coin(2'b11);
        put_coin(2'b11);
        cmp("t3_credit8", credit_o, 8);
        cmp("t3_bits", change_bits_o, 3);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            change_ready_i = (i % 2 == 0);
            cmp("t3_countdown", credit_o, 3 - (i + 1) / 2);
            cmp("t3_valid_held", change_valid_o, 1);
            tick();
        end
        change_ready_i = 1'b0;
        cmp("t3_credit_end", credit_o, 0);
        cmp("t3_valid_end", change_valid_o, 0);
        cmp("t3_bits_end", change_bits_o, 0);
        cmp("t3_idle", busy_o, 0);

        // Invalid coin, coin up to the ceiling, coin during vend
        put_coin(2'b00);
        cmp("t4_invalid_reject", coin_reject_o, 1);
        cmp("t4_invalid_credit", credit_o, 0);
        put_coin(2'b11);
        put_coin(2'b00);
        cmp("t4_invalid_reject2", coin_reject_o, 1);
        cmp("t4_credit_kept", credit_o, 4);
        put_coin(2'b11);
        cmp("t4_ceiling_accept", coin_accept_o, 1);
        cmp("t4_credit8", credit_o, 8);
        put_coin(2'b01);
        cmp("t4_busy_reject", coin_reject_o, 1);
        cmp("t4_busy_credit", credit_o, 8);
        change_ready_i = 1'b1;
        drain(n_item, n_hs);
        cmp("t4_handshakes", n_hs, 3);

        // Cancel with a coin in the same cycle at credit 3
        change_ready_i = 1'b0;
        put_coin(2'b10);
        put_coin(2'b01);
        cmp("t5_credit3", credit_o, 3);
        cancel_i = 1'b1;
        put_coin(2'b01);
        cancel_i = 1'b0;
        cmp("t5_reject", coin_reject_o, CANCEL_EN ? 1 : 0);
        cmp("t5_accept", coin_accept_o, CANCEL_EN ? 0 : 1);
        cmp("t5_credit", credit_o, CANCEL_EN ? 3 : 4);
        cmp("t5_valid", change_valid_o, CANCEL_EN ? 1 : 0);
        cmp("t5_bits", change_bits_o, CANCEL_EN ? 3 : 0);
        change_ready_i = 1'b1;
        drain(n_item, n_hs);
        cmp("t5_no_item", n_item, 0);
        cmp("t5_refund_units", n_hs, CANCEL_EN ? 3 : 0);
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        cmp("t5_credit_after_reset", credit_o, 0);

        // Reset in CHANGE with two units still owed
        change_ready_i = 1'b0;
        put_coin(2'b11);
        put_coin(2'b11);
        wait_valid();
        change_ready_i = 1'b1;
        tick();
        change_ready_i = 1'b0;
        cmp("t6_remaining2", credit_o, 2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        cmp("t6_credit", credit_o, 0);
        cmp("t6_valid", change_valid_o, 0);
        cmp("t6_busy", busy_o, 0);
        cmp("t6_bits", change_bits_o, 0);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            reset_i        = ($urandom_range(0, 199) == 0);
            coin_valid_i   = ($urandom_range(0, 2) == 0);
            coin_value_i   = 2'($urandom_range(0, 3));
            cancel_i       = ($urandom_range(0, 7) == 0);
            change_ready_i = ($urandom_range(0, 1) == 1);
            tick();
        end
        reset_i = 1'b0; coin_valid_i = 1'b0; cancel_i = 1'b0; change_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) tick();

        cmp("b_idle", b_busy, 0);
        cmp("b_credit_end", b_credit, 0);
        cmp("b_valid_end", b_change_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
